vga_tile_scanner: RTL

VGA_TILE_SCANNER -- requirements
Module: vga_tile_scanner

---
 rtl/vga_tile_scanner.sv | 160 ++++++++++++++++
 1 files changed

// File: rtl/vga_tile_scanner.sv
// VGA raster timing generator that also reports the position as a tile cell plus pixel offset.
// Define VGA_TILE_SCANNER_FRAME_COUNT_EN to build the 8-bit wrapping frame counter.
module vga_tile_scanner #(
  parameter int H_SYNC_CYCLES = 92,
  parameter int H_BACK_PORCH  = 50,
  parameter int H_DISPLAY     = 640,
  parameter int H_FRONT_PORCH = 18,
  parameter int V_SYNC_CYCLES = 2,
  parameter int V_BACK_PORCH  = 33,
  parameter int V_DISPLAY     = 480,
  parameter int V_FRONT_PORCH = 10,
  parameter int TILE_SIZE     = 32
) (
  input  logic       i_Clk,
  input  logic       i_reset_n,
  output logic       o_VGA_HSync,
  output logic       o_VGA_VSync,
  output logic       o_active,
  output logic [4:0] o_cell_x,
  output logic [3:0] o_cell_y,
  output logic [4:0] o_pix_x,
  output logic [4:0] o_pix_y,
  output logic       o_frame_tick,
  output logic [7:0] o_frame_count
);

  localparam int H_LINE  = H_SYNC_CYCLES + H_BACK_PORCH + H_DISPLAY + H_FRONT_PORCH;
  localparam int V_FRAME = V_SYNC_CYCLES + V_BACK_PORCH + V_DISPLAY + V_FRONT_PORCH;
  localparam int HW      = $clog2(H_LINE);
  localparam int VW      = $clog2(V_FRAME);

  localparam logic [HW-1:0] H_LAST      = HW'(H_LINE - 1);
  localparam logic [HW-1:0] H_SYNC_END  = HW'(H_SYNC_CYCLES);
  localparam logic [HW-1:0] H_ACT_START = HW'(H_SYNC_CYCLES + H_BACK_PORCH);
  localparam logic [HW-1:0] H_ACT_LAST  = HW'(H_SYNC_CYCLES + H_BACK_PORCH + H_DISPLAY - 1);
  localparam logic [VW-1:0] V_LAST      = VW'(V_FRAME - 1);
  localparam logic [VW-1:0] V_SYNC_END  = VW'(V_SYNC_CYCLES);
  localparam logic [VW-1:0] V_ACT_START = VW'(V_SYNC_CYCLES + V_BACK_PORCH);
  localparam logic [VW-1:0] V_ACT_LAST  = VW'(V_SYNC_CYCLES + V_BACK_PORCH + V_DISPLAY - 1);
  localparam logic [4:0]    TILE_LAST   = 5'(TILE_SIZE - 1);

  logic [HW-1:0] h_q, h_d;
  logic [VW-1:0] v_q, v_d;
  logic          line_end;
  logic          h_act_d, v_act_d;
  logic          hsync_q, hsync_d;
  logic          vsync_q, vsync_d;
  logic          active_q, active_d;
  logic [4:0]    cell_x_q, cell_x_d;
  logic [3:0]    cell_y_q, cell_y_d;
  logic [4:0]    pix_x_q, pix_x_d;
  logic [4:0]    pix_y_q, pix_y_d;
  logic          frame_tick_q, frame_tick_d;

  always_comb begin
    line_end = (h_q == H_LAST);
    h_d      = line_end ? '0 : h_q + HW'(1);
    v_d      = v_q;
    if (line_end) begin
      v_d = (v_q == V_LAST) ? '0 : v_q + VW'(1);
    end
  end

  // Every output register is loaded from the next counter values, so the
  // registered outputs always describe the position the counters now hold.
  always_comb begin
    h_act_d  = (h_d >= H_ACT_START) && (h_d <= H_ACT_LAST);
    v_act_d  = (v_d >= V_ACT_START) && (v_d <= V_ACT_LAST);
    hsync_d  = (h_d >= H_SYNC_END);
    vsync_d  = (v_d >= V_SYNC_END);
    active_d = h_act_d && v_act_d;

    pix_x_d  = '0;
    cell_x_d = '0;
    if (h_act_d && (h_d != H_ACT_START)) begin
      if (pix_x_q == TILE_LAST) begin
        pix_x_d  = '0;
        cell_x_d = cell_x_q + 5'd1;
      end else begin
        pix_x_d  = pix_x_q + 5'd1;
        cell_x_d = cell_x_q;
      end
    end

    // Row coordinates only move at a line boundary and hold through h blanking.
    pix_y_d  = pix_y_q;
    cell_y_d = cell_y_q;
    if (line_end) begin
      pix_y_d  = '0;
      cell_y_d = '0;
      if (v_act_d && (v_d != V_ACT_START)) begin
        if (pix_y_q == TILE_LAST) begin
          pix_y_d  = '0;
          cell_y_d = cell_y_q + 4'd1;
        end else begin
          pix_y_d  = pix_y_q + 5'd1;
          cell_y_d = cell_y_q;
        end
      end
    end

    frame_tick_d = (h_d == H_LAST) && (v_d == V_ACT_LAST);
  end

  always_ff @(posedge i_Clk) begin
    if (!i_reset_n) begin
      h_q          <= '0;
      v_q          <= '0;
      hsync_q      <= 1'b0;
      vsync_q      <= 1'b0;
      active_q     <= 1'b0;
      cell_x_q     <= '0;
      cell_y_q     <= '0;
      pix_x_q      <= '0;
      pix_y_q      <= '0;
      frame_tick_q <= 1'b0;
    end else begin
      h_q          <= h_d;
      v_q          <= v_d;
      hsync_q      <= hsync_d;
      vsync_q      <= vsync_d;
      active_q     <= active_d;
      cell_x_q     <= cell_x_d;
      cell_y_q     <= cell_y_d;
      pix_x_q      <= pix_x_d;
      pix_y_q      <= pix_y_d;
      frame_tick_q <= frame_tick_d;
    end
  end

`ifdef VGA_TILE_SCANNER_FRAME_COUNT_EN
  logic [7:0] frame_count_q, frame_count_d;

  always_comb begin
    frame_count_d = frame_tick_q ? frame_count_q + 8'd1 : frame_count_q;
  end

  always_ff @(posedge i_Clk) begin
    if (!i_reset_n) begin
      frame_count_q <= '0;
    end else begin
      frame_count_q <= frame_count_d;
    end
  end

  assign o_frame_count = frame_count_q;
`else
  assign o_frame_count = 8'd0;
`endif

  assign o_VGA_HSync  = hsync_q;
  assign o_VGA_VSync  = vsync_q;
  assign o_active     = active_q;
  assign o_cell_x     = cell_x_q;
  assign o_cell_y     = cell_y_q;
  assign o_pix_x      = pix_x_q;
  assign o_pix_y      = pix_y_q;
  assign o_frame_tick = frame_tick_q;

endmodule
